// File: rtl/fb_banked_dp_pkg.sv
// Shared types and helpers for the banked dual-port framebuffer.
package fb_pkg;

  // Width of the bank-select field as carried internally (covers up to 16 banks).
  localparam int unsigned SEL_W = 4;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  // Bank index of a word address: low address bits, masked to the bank count.
  function automatic logic [SEL_W-1:0] bank_of(input logic [SEL_W-1:0] addr_lo,
                                               input int unsigned       num_banks);
    logic [SEL_W-1:0] mask;
    mask = SEL_W'(num_banks - 1);
    return addr_lo & mask;
  endfunction

endpackage

// File: rtl/fb_banked_dp_bank.sv
// One single-port SRAM bank with a registered read port (1-cycle latency).
// Behavioural array; the implementation flow swaps in the macro wrapper.
module fb_bank #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ROW_W  = 15
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ROW_W-1:0]  row_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ROW_W];
  logic [DATA_W-1:0] rdata_q;

  // Single access per cycle: write the row, or capture it into the read register.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[row_i] <= wdata_i;
      else      rdata_q      <= mem_q[row_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fb_banked_dp.sv
// Two request/ready ports over NUM_BANKS address-interleaved single-port banks,
// round-robin arbitration on same-bank collisions, saturating conflict counter.
module fb_banked_dp
  import fb_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int unsigned BANK_W = $clog2(NUM_BANKS);
  localparam int unsigned ROW_W  = ADDR_W - BANK_W;

  typedef struct packed {
    logic              we;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] wdata;
  } fb_req_t;

  logic [SEL_W-1:0]  a_bank, b_bank;
  logic              same_bank;
  prio_e             prio_q, prio_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [SEL_W-1:0]  a_bank_q, a_bank_d, b_bank_q, b_bank_d;
  logic [DATA_W-1:0] a_hold_q, a_hold_d, b_hold_q, b_hold_d;
  logic [DATA_W-1:0] a_mux, b_mux;
  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];
  fb_req_t           a_fwd, b_fwd;

  // Arbitration: grant both unless they collide on one bank, then follow prio.
  always_comb begin
    a_bank    = bank_of(SEL_W'(a_addr), NUM_BANKS);
    b_bank    = bank_of(SEL_W'(b_addr), NUM_BANKS);
    a_fwd     = '{we: a_we, row: a_addr[ADDR_W-1:BANK_W], wdata: a_wdata};
    b_fwd     = '{we: b_we, row: b_addr[ADDR_W-1:BANK_W], wdata: b_wdata};
    same_bank = a_req && b_req && (a_bank == b_bank);
    a_ready   = !rst && a_req && (!same_bank || prio_q == PRIO_A);
    b_ready   = !rst && b_req && (!same_bank || prio_q == PRIO_B);
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    if (!rst && same_bank) begin
      prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    logic    a_hit, b_hit;
    fb_req_t req;

    // Route the granted port (at most one per bank) to this bank.
    always_comb begin
      a_hit = a_ready && (a_bank == SEL_W'(i));
      b_hit = b_ready && (b_bank == SEL_W'(i));
      req   = a_hit ? a_fwd : b_fwd;
    end

    fb_bank #(
      .DATA_W (DATA_W),
      .ROW_W  (ROW_W)
    ) u_bank (
      .clk     (clk),
      .en_i    (a_hit || b_hit),
      .we_i    (req.we),
      .row_i   (req.row),
      .wdata_i (req.wdata),
      .rdata_o (bank_rdata[i])
    );
  end

  // Read-return path: select the bank recorded at accept; hold last data when idle.
  always_comb begin
    a_mux = '0;
    b_mux = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (a_bank_q == SEL_W'(i)) a_mux = bank_rdata[i];
      if (b_bank_q == SEL_W'(i)) b_mux = bank_rdata[i];
    end
    a_rvalid_d = a_ready && !a_we;
    b_rvalid_d = b_ready && !b_we;
    a_bank_d   = a_rvalid_d ? a_bank : a_bank_q;
    b_bank_d   = b_rvalid_d ? b_bank : b_bank_q;
    // The bank's read register can be overwritten by the other port later, so
    // the returned word is captured locally at the end of its valid cycle.
    a_hold_d   = a_rvalid_q ? a_mux : a_hold_q;
    b_hold_d   = b_rvalid_q ? b_mux : b_hold_q;
    a_rdata    = a_rvalid_q ? a_mux : a_hold_q;
    b_rdata    = b_rvalid_q ? b_mux : b_hold_q;
  end

  // Control state: priority, statistics, read-return pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= PRIO_A;
      cnt_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_bank_q   <= '0;
      b_bank_q   <= '0;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
    end else begin
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_bank_q   <= a_bank_d;
      b_bank_q   <= b_bank_d;
      a_hold_q   <= a_hold_d;
      b_hold_q   <= b_hold_d;
    end
  end

  assign a_rvalid     = a_rvalid_q;
  assign b_rvalid     = b_rvalid_q;
  assign conflict_cnt = cnt_q;

endmodule
